// File: rtl/sigmoid_act_pipe_pkg.sv
// Shared definitions for the autoencoder activation unit: mode codes,
// default widths and the sigmoid table contents.
package sigmoid_act_pipe_pkg;

    localparam int ACT_DATA_W    = 16;
    localparam int ACT_FRAC_W    = 8;
    localparam int SIG_LUT_DEPTH = 112;
    localparam int SIG_LUT_W     = ACT_FRAC_W + 1;
    localparam int SIG_LUT_AW    = $clog2(SIG_LUT_DEPTH);

    typedef enum logic [1:0] {
        ACT_SIG_INTERP  = 2'b00,
        ACT_SIG_NEAREST = 2'b01,
        ACT_RELU        = 2'b10,
        ACT_PASS        = 2'b11
    } act_mode_e;

    // lut[i] = min(floor(sigmoid((i-56)/8) * 256), 255); generated for
    // FRAC_W=8, SEG_SHIFT=5, LUT_DEPTH=112.
    localparam logic [SIG_LUT_W-1:0] SIG_LUT_TABLE [0:SIG_LUT_DEPTH-1] = '{
        9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,    //   0
        9'd0,   9'd0,   9'd0,   9'd0,   9'd1,   9'd1,   9'd1,   9'd1,    //   8
        9'd1,   9'd1,   9'd2,   9'd2,   9'd2,   9'd3,   9'd3,   9'd4,    //  16
        9'd4,   9'd5,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,   //  24
        9'd12,  9'd13,  9'd15,  9'd17,  9'd19,  9'd21,  9'd24,  9'd27,   //  32
        9'd30,  9'd34,  9'd37,  9'd42,  9'd46,  9'd51,  9'd57,  9'd62,   //  40
        9'd68,  9'd75,  9'd82,  9'd89,  9'd96,  9'd104, 9'd112, 9'd120,  //  48
        9'd128, 9'd135, 9'd143, 9'd151, 9'd159, 9'd166, 9'd173, 9'd180,  //  56
        9'd187, 9'd193, 9'd198, 9'd204, 9'd209, 9'd213, 9'd218, 9'd221,  //  64
        9'd225, 9'd228, 9'd231, 9'd234, 9'd236, 9'd238, 9'd240, 9'd242,  //  72
        9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd250,  //  80
        9'd251, 9'd251, 9'd252, 9'd252, 9'd253, 9'd253, 9'd253, 9'd254,  //  88
        9'd254, 9'd254, 9'd254, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255,  //  96
        9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255   // 104
    };

    // Table lookup; callers guarantee idx < SIG_LUT_DEPTH.
    function automatic logic [SIG_LUT_W-1:0] sig_lut_entry(input logic [SIG_LUT_AW-1:0] idx);
        return SIG_LUT_TABLE[idx];
    endfunction

endpackage

// File: rtl/sigmoid_act_pipe_rom.sv
// Dual-read-port sigmoid table with registered outputs and a shared read enable.
module sigmoid_lut_rom
    import sigmoid_act_pipe_pkg::*;
#(
    parameter int LUT_DEPTH = SIG_LUT_DEPTH,
    parameter int ENTRY_W   = SIG_LUT_W,
    parameter int ADDR_W    = $clog2(LUT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [ADDR_W-1:0]  addr_a,
    input  logic [ADDR_W-1:0]  addr_b,
    output logic [ENTRY_W-1:0] data_a,
    output logic [ENTRY_W-1:0] data_b
);

    logic [ENTRY_W-1:0] data_a_r;
    logic [ENTRY_W-1:0] data_b_r;

    // Out-of-range addresses read as zero so the table is never overrun.
    function automatic logic [ENTRY_W-1:0] read_entry(input logic [ADDR_W-1:0] addr);
        logic [ENTRY_W-1:0] val;
        if (int'(addr) < LUT_DEPTH) begin
            val = sig_lut_entry(addr);
        end else begin
            val = {ENTRY_W{1'b0}};
        end
        return val;
    endfunction

    // Registered read of both ports when the downstream stage loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a_r <= {ENTRY_W{1'b0}};
            data_b_r <= {ENTRY_W{1'b0}};
        end else if (en) begin
            data_a_r <= read_entry(addr_a);
            data_b_r <= read_entry(addr_b);
        end
    end

    assign data_a = data_a_r;
    assign data_b = data_b_r;

endmodule

// File: rtl/sigmoid_act_pipe.sv
// Three-stage activation pipe: decode, table read, compute. Valid/ready
// handshake with full throughput; each stage loads when empty or advancing.
module sigmoid_act_pipe
    import sigmoid_act_pipe_pkg::*;
#(
    parameter int DATA_W    = ACT_DATA_W,
    parameter int FRAC_W    = ACT_FRAC_W,
    parameter int SEG_SHIFT = 5,
    parameter int LUT_DEPTH = SIG_LUT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int IDX_W  = $clog2(LUT_DEPTH);
    localparam int ENT_W  = FRAC_W + 1;
    localparam int PROD_W = FRAC_W + 2 + SEG_SHIFT;
    localparam int HALF   = LUT_DEPTH / 2;
    localparam int signed RANGE_LIM = HALF * (2 ** SEG_SHIFT);
    localparam logic [ENT_W-1:0] SAT_HI   = ENT_W'((2 ** FRAC_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_DEPTH - 1);

    // Valid chain and per-stage load enables.
    logic v1_r, v2_r, v3_r;
    logic en1_s, en2_s, en3_s;

    assign en3_s    = !v3_r || out_ready;
    assign en2_s    = !v2_r || en3_s;
    assign en1_s    = !v1_r || en2_s;
    assign in_ready = en1_s;

    // Stage 1 decode signals.
    logic signed [31:0]    x_ext_s;
    logic                  lo_s, hi_s;
    logic [IDX_W-1:0]      idx_s;
    logic [SEG_SHIFT-1:0]  frac_s;

    // Range flags, table index and segment fraction from the raw input.
    always_comb begin
        x_ext_s = {{(32-DATA_W){in_data[DATA_W-1]}}, in_data};
        lo_s    = x_ext_s < -RANGE_LIM;
        hi_s    = x_ext_s >= RANGE_LIM;
        idx_s   = IDX_W'((x_ext_s >>> SEG_SHIFT) + 32'(HALF));
        frac_s  = in_data[SEG_SHIFT-1:0];
    end

    logic                 lo1_r, hi1_r, last1_r;
    logic [IDX_W-1:0]     idx1_r;
    logic [SEG_SHIFT-1:0] frac1_r;
    act_mode_e            mode1_r;
    logic [DATA_W-1:0]    x1_r;

    // Stage 1 register: capture decoded beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            lo1_r   <= 1'b0;
            hi1_r   <= 1'b0;
            last1_r <= 1'b0;
            idx1_r  <= {IDX_W{1'b0}};
            frac1_r <= {SEG_SHIFT{1'b0}};
            mode1_r <= ACT_SIG_INTERP;
            x1_r    <= {DATA_W{1'b0}};
        end else if (en1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                lo1_r   <= lo_s;
                hi1_r   <= hi_s;
                last1_r <= in_last;
                idx1_r  <= idx_s;
                frac1_r <= frac_s;
                mode1_r <= act_mode_e'(in_mode);
                x1_r    <= in_data;
            end
        end
    end

    // Stage 2: table read. The last entry's upper neighbour is the
    // saturation value, so the second port re-reads idx instead of idx+1.
    logic [IDX_W-1:0] addr_b_s;
    logic [ENT_W-1:0] a_s, b_rom_s;

    assign addr_b_s = (idx1_r == LAST_IDX) ? idx1_r : (idx1_r + IDX_W'(1));

    sigmoid_lut_rom #(
        .LUT_DEPTH (LUT_DEPTH),
        .ENTRY_W   (ENT_W),
        .ADDR_W    (IDX_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en     (en2_s && v1_r),
        .addr_a (idx1_r),
        .addr_b (addr_b_s),
        .data_a (a_s),
        .data_b (b_rom_s)
    );

    logic                 lo2_r, hi2_r, end2_r, last2_r;
    logic [SEG_SHIFT-1:0] frac2_r;
    act_mode_e            mode2_r;
    logic [DATA_W-1:0]    x2_r;

    // Stage 2 register: sideband travelling alongside the table read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r    <= 1'b0;
            lo2_r   <= 1'b0;
            hi2_r   <= 1'b0;
            end2_r  <= 1'b0;
            last2_r <= 1'b0;
            frac2_r <= {SEG_SHIFT{1'b0}};
            mode2_r <= ACT_SIG_INTERP;
            x2_r    <= {DATA_W{1'b0}};
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                lo2_r   <= lo1_r;
                hi2_r   <= hi1_r;
                end2_r  <= (idx1_r == LAST_IDX);
                last2_r <= last1_r;
                frac2_r <= frac1_r;
                mode2_r <= mode1_r;
                x2_r    <= x1_r;
            end
        end
    end

    // Stage 3 compute.
    logic [ENT_W-1:0]         b_s;
    logic signed [ENT_W:0]    diff_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [ENT_W-1:0]         interp_s;
    logic [ENT_W-1:0]         sig_s;
    logic [DATA_W-1:0]        y_s;

    // Linear interpolation between neighbouring table entries.
    always_comb begin
        b_s      = end2_r ? SAT_HI : b_rom_s;
        diff_s   = $signed({1'b0, b_s}) - $signed({1'b0, a_s});
        prod_s   = {{SEG_SHIFT{diff_s[ENT_W]}}, diff_s} * {{(ENT_W+1){1'b0}}, frac2_r};
        interp_s = a_s + ENT_W'(prod_s >>> SEG_SHIFT);
    end

    // Sigmoid value with saturation outside the table range.
    always_comb begin
        if (lo2_r) begin
            sig_s = {ENT_W{1'b0}};
        end else if (hi2_r) begin
            sig_s = SAT_HI;
        end else if (mode2_r == ACT_SIG_NEAREST) begin
            sig_s = a_s;
        end else begin
            sig_s = interp_s;
        end
    end

    // Per-beat mode select.
    always_comb begin
        y_s = {DATA_W{1'b0}};
        case (mode2_r)
            ACT_SIG_INTERP,
            ACT_SIG_NEAREST: y_s = {{(DATA_W-ENT_W){1'b0}}, sig_s};
            ACT_RELU:        y_s = x2_r[DATA_W-1] ? {DATA_W{1'b0}} : x2_r;
            ACT_PASS:        y_s = x2_r;
            default:         y_s = {DATA_W{1'b0}};
        endcase
    end

    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;

    // Output register; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_r       <= 1'b0;
            out_data_r <= {DATA_W{1'b0}};
            out_last_r <= 1'b0;
        end else if (en3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_data_r <= y_s;
                out_last_r <= last2_r;
            end
        end
    end

    assign out_valid = v3_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_sigmoid_act_pipe.sv
// Scoreboard bench for sigmoid_act_pipe.
module tb_sigmoid_act_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic [1:0]  in_mode = 2'b00;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;

    sigmoid_act_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [1:0]  mode;
        logic        last;
        bit          has_want;
        logic [15:0] want;
    } beat_t;

    typedef struct {
        logic [15:0] y;
        logic        last;
        int          cyc;
    } exp_t;

    beat_t stim_q[$];
    exp_t  sb_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit    lat_chk = 1'b1;
    bit    stall_pend = 1'b0;
    logic [15:0] held_data;
    logic        held_last;

    // Reference sigmoid table computed from the real function.
    function automatic int lut_ref(int i);
        real xr, s;
        int  v;
        xr = real'(i - 56) / 8.0;
        s  = 256.0 / (1.0 + $exp(-xr));
        v  = int'($floor(s));
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic [15:0] model(logic [15:0] x, logic [1:0] m);
        int xs, idx, fr, a, b, y;
        xs = $signed(x);
        if (m == 2'b10) return (xs < 0) ? 16'h0000 : x;
        if (m == 2'b11) return x;
        if (xs < -1792) return 16'd0;
        if (xs >= 1792) return 16'd255;
        idx = (xs >>> 5) + 56;
        fr  = xs & 31;
        a   = lut_ref(idx);
        b   = (idx == 111) ? 255 : lut_ref(idx + 1);
        if (m == 2'b01) y = a;
        else            y = a + ((b - a) * fr) / 32;
        return 16'(y);
    endfunction

    task automatic add(input logic [15:0] x, input logic [1:0] m, input logic last,
                       input bit has_want, input logic [15:0] want);
        beat_t b;
        b.x = x; b.mode = m; b.last = last; b.has_want = has_want; b.want = want;
        stim_q.push_back(b);
    endtask

    // One clock: drive at the falling edge, check shortly after, record handshakes.
    task automatic tick();
        int    occ;
        logic  acc, emit;
        exp_t  e;
        beat_t b;
        @(negedge clk);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        if (stim_q.size() > 0) begin
            b = stim_q[0];
            in_valid = 1'b1; in_data = b.x; in_mode = b.mode; in_last = b.last;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        occ = sb_q.size();
        total++;
        if (in_ready !== !(occ == 3 && !out_ready)) begin
            bad++;
            $display("FAIL in_ready_rule got=%b want=%b occ=%0d", in_ready, !(occ == 3 && !out_ready), occ);
        end
        if (stall_pend) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                bad++;
                $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b", out_valid, out_data, out_last, held_data, held_last);
            end
        end
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (emit) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output got=%h want=none", out_data);
            end else begin
                e = sb_q.pop_front();
                total++;
                if (out_data !== e.y) begin
                    bad++;
                    $display("FAIL out_data got=%h want=%h", out_data, e.y);
                end
                total++;
                if (out_last !== e.last) begin
                    bad++;
                    $display("FAIL out_last got=%b want=%b", out_last, e.last);
                end
                if (lat_chk) begin
                    total++;
                    if (cyc - e.cyc != 3) begin
                        bad++;
                        $display("FAIL latency got=%0d want=3", cyc - e.cyc);
                    end
                end
            end
        end
        stall_pend = out_valid && !out_ready;
        held_data  = out_data;
        held_last  = out_last;
        if (acc) begin
            b = stim_q.pop_front();
            e.y    = b.has_want ? b.want : model(b.x, b.mode);
            e.last = b.last;
            e.cyc  = cyc;
            sb_q.push_back(e);
        end
        cyc++;
    endtask

    // Run until all stimulus is consumed and every expected beat has emerged.
    task automatic drain();
        int n = 0;
        while ((stim_q.size() > 0 || sb_q.size() > 0) && n < 400) begin
            tick();
            n++;
        end
        if (stim_q.size() > 0 || sb_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d/%0d want=0/0", stim_q.size(), sb_q.size());
            stim_q.delete();
            sb_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h want=0000", out_data); end
        total++;
        if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_interp();
        ready_mode = 0; lat_chk = 1'b1;
        add(16'd0,  2'b00, 1'b0, 1'b1, 16'd128);
        add(16'd16, 2'b00, 1'b0, 1'b1, 16'd131);
        add(16'd32, 2'b00, 1'b1, 1'b1, 16'd135);
        drain();
    endtask

    task automatic test_nearest();
        add(16'd16, 2'b01, 1'b1, 1'b1, 16'd128);
        drain();
    endtask

    task automatic test_saturation();
        add(16'hF8FF, 2'b00, 1'b0, 1'b1, 16'd0);
        add(16'd1792, 2'b00, 1'b0, 1'b1, 16'd255);
        add(16'h7FFF, 2'b00, 1'b0, 1'b1, 16'd255);
        add(16'd1791, 2'b00, 1'b0, 1'b1, 16'd255);
        add(16'h8000, 2'b00, 1'b0, 1'b1, 16'd0);
        add(16'hF8FF, 2'b01, 1'b0, 1'b1, 16'd0);
        add(16'd1792, 2'b01, 1'b0, 1'b1, 16'd255);
        add(16'hF900, 2'b00, 1'b1, 1'b1, 16'd0);
        drain();
    endtask

    task automatic test_relu_pass();
        add(16'hFF00, 2'b10, 1'b0, 1'b1, 16'h0000);
        add(16'h0180, 2'b10, 1'b0, 1'b1, 16'h0180);
        add(16'hFF00, 2'b11, 1'b1, 1'b1, 16'hFF00);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [0:7];
        xs = '{16'h0010, 16'hFF00, 16'h0180, 16'hFFE0, 16'h00A5, 16'hFC37, 16'h7FFF, 16'h0040};
        for (int i = 0; i < 8; i++) begin
            add(xs[i], 2'(i % 4), 1'(i == 7), 1'b0, 16'h0000);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int v;
        ready_mode = 1; lat_chk = 1'b0;
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 4400)) - 2200;
            add(16'(v), 2'($urandom_range(0, 3)), 1'(i % 5 == 4), 1'b0, 16'h0000);
        end
        drain();
        ready_mode = 0; lat_chk = 1'b1;
    endtask

    task automatic test_reset_inflight();
        ready_mode = 2; lat_chk = 1'b0;
        add(16'd16,   2'b00, 1'b1, 1'b0, 16'h0000);
        add(16'd32,   2'b01, 1'b0, 1'b0, 16'h0000);
        add(16'h0180, 2'b11, 1'b0, 1'b0, 16'h0000);
        add(16'd64,   2'b00, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL inflight_rst_valid got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL inflight_rst_ready got=%b want=1", in_ready); end
        total++;
        if (out_data !== 16'h0000 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL inflight_rst_data got=%h/%b want=0000/0", out_data, out_last);
        end
        stim_q.delete();
        sb_q.delete();
        stall_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0; lat_chk = 1'b1;
        add(16'd0, 2'b00, 1'b0, 1'b1, 16'd128);
        drain();
    endtask

    initial begin
        test_reset();
        test_interp();
        test_nearest();
        test_saturation();
        test_relu_pass();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
